// File: rtl/l1_trace_sequencer.sv
// Trace command sequencer in front of the split L1 processor model: owns per-set line storage,
// decides fill MESI state, commits returned sets, keeps hit/miss statistics and runs clear/dump sweeps.
package my_struct_package;
   localparam int TAG_W = 12;
   localparam int IDX_W = 14;

   localparam logic [1:0] MESI_I = 2'd0;
   localparam logic [1:0] MESI_S = 2'd1;
   localparam logic [1:0] MESI_E = 2'd2;
   localparam logic [1:0] MESI_M = 2'd3;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [IDX_W-1:0] index;
   } address_t;

   typedef struct packed {
      logic [3:0] n;
      address_t   address;
   } command_t;

   typedef struct packed {
      logic [1:0]       mesi;
      logic [TAG_W-1:0] tag;
      logic [2:0]       lru;
   } cache_line_t;
endpackage

module l1_trace_sequencer
   import my_struct_package::*;
#(
   parameter int SET_BITS = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cmd_valid,
   input  command_t            cmd,
   output logic                cmd_ready,
   output logic                busy,
   output command_t            proc_instruction,
   output cache_line_t [3:0]   proc_line_i,
   output cache_line_t [7:0]   proc_line_d,
   output cache_line_t         proc_block_in,
   input  cache_line_t [3:0]   proc_return_i,
   input  cache_line_t [7:0]   proc_return_d,
   input  cache_line_t         proc_block_out,
   output logic                dump_valid,
   output logic [SET_BITS-1:0] dump_set,
   output logic [31:0]         read_count,
   output logic [31:0]         write_count,
   output logic [31:0]         hit_count,
   output logic [31:0]         miss_count,
   output logic [31:0]         writeback_count
);

   localparam int NSETS = 1 << SET_BITS;
   localparam logic [SET_BITS-1:0] SET_LAST = '1;

   typedef enum logic [2:0] {
      RESET_CLEAR = 3'd0,
      IDLE        = 3'd1,
      FETCH       = 3'd2,
      EXEC        = 3'd3,
      CLEAR       = 3'd4,
      DUMP        = 3'd5
   } state_t;

   state_t state, state_next;

   logic [SET_BITS-1:0] s;
   command_t            cmd_q;
   logic                hit_q;
   logic                hit;
   logic [1:0]          hit_mesi;
   logic [1:0]          blk_mesi;
   logic                dump_any;
   logic [SET_BITS-1:0] set_q;
   logic                use_i;
   logic                unused_blk;

   cache_line_t [7:0] mem_d [NSETS];
   cache_line_t [3:0] mem_i [NSETS];

   assign set_q      = cmd_q.address.index[SET_BITS-1:0];
   assign use_i      = (cmd_q.n == 4'd2);
   assign unused_blk = ^{proc_block_out.tag, proc_block_out.lru};

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= RESET_CLEAR;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         RESET_CLEAR, CLEAR, DUMP: if (s == SET_LAST) state_next = IDLE;
         IDLE: begin
            if (cmd_valid) begin
               if (cmd.n <= 4'd4)      state_next = FETCH;
               else if (cmd.n == 4'd8) state_next = CLEAR;
               else if (cmd.n == 4'd9) state_next = DUMP;
            end
         end
         FETCH:   state_next = EXEC;
         EXEC:    state_next = IDLE;
         default: state_next = RESET_CLEAR;
      endcase
   end

   always_comb begin
      cmd_ready  = (state == IDLE);
      busy       = (state != IDLE);
      dump_valid = (state == DUMP) && dump_any;
      dump_set   = (state == DUMP) ? s : '0;
   end

   // Invalid ways never hit, even though cleared ways carry tag 0.
   always_comb begin
      hit      = 1'b0;
      hit_mesi = MESI_I;
      if (use_i) begin
         for (int w = 0; w < 4; w++)
            if (!hit && mem_i[set_q][w].mesi != MESI_I && mem_i[set_q][w].tag == cmd_q.address.tag) begin
               hit      = 1'b1;
               hit_mesi = mem_i[set_q][w].mesi;
            end
      end else begin
         for (int w = 0; w < 8; w++)
            if (!hit && mem_d[set_q][w].mesi != MESI_I && mem_d[set_q][w].tag == cmd_q.address.tag) begin
               hit      = 1'b1;
               hit_mesi = mem_d[set_q][w].mesi;
            end
      end
   end

   always_comb begin
      blk_mesi = MESI_I;
      case (cmd_q.n)
         4'd0, 4'd2: blk_mesi = hit ? hit_mesi : MESI_E;
         4'd1:       blk_mesi = MESI_M;
         4'd4:       blk_mesi = hit ? MESI_S : MESI_I;
         default:    blk_mesi = MESI_I;
      endcase
   end

   always_comb begin
      dump_any = 1'b0;
      for (int w = 0; w < 8; w++) dump_any = dump_any | (mem_d[s][w].mesi != MESI_I);
      for (int w = 0; w < 4; w++) dump_any = dump_any | (mem_i[s][w].mesi != MESI_I);
   end

   // Storage has no reset; the RESET_CLEAR sweep initialises it.
   always_ff @(posedge clk) begin
      if (state == RESET_CLEAR || state == CLEAR) begin
         for (int w = 0; w < 8; w++) mem_d[s][w] <= '{mesi: MESI_I, tag: '0, lru: 3'(w)};
         for (int w = 0; w < 4; w++) mem_i[s][w] <= '{mesi: MESI_I, tag: '0, lru: 3'(w)};
      end else if (state == EXEC) begin
         if (use_i) mem_i[set_q] <= proc_return_i;
         else       mem_d[set_q] <= proc_return_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s                <= '0;
         cmd_q            <= '0;
         hit_q            <= 1'b0;
         proc_instruction <= '0;
         proc_line_i      <= '0;
         proc_line_d      <= '0;
         proc_block_in    <= '0;
         read_count       <= '0;
         write_count      <= '0;
         hit_count        <= '0;
         miss_count       <= '0;
         writeback_count  <= '0;
      end else begin
         if (state == RESET_CLEAR || state == CLEAR || state == DUMP) s <= s + 1'b1;
         else                                                         s <= '0;

         if (state == IDLE && cmd_valid) cmd_q <= cmd;

         if (state == FETCH) begin
            proc_instruction <= cmd_q;
            proc_line_i      <= mem_i[set_q];
            proc_line_d      <= mem_d[set_q];
            proc_block_in    <= '{mesi: blk_mesi, tag: cmd_q.address.tag, lru: 3'd0};
            hit_q            <= hit;
         end

         if (state == CLEAR && s == '0) begin
            read_count      <= '0;
            write_count     <= '0;
            hit_count       <= '0;
            miss_count      <= '0;
            writeback_count <= '0;
         end

         if (state == EXEC && cmd_q.n <= 4'd2) begin
            if (cmd_q.n == 4'd1) write_count <= sat_inc(write_count);
            else                 read_count  <= sat_inc(read_count);
            if (hit_q) hit_count  <= sat_inc(hit_count);
            else       miss_count <= sat_inc(miss_count);
            if (!hit_q && proc_block_out.mesi == MESI_M) writeback_count <= sat_inc(writeback_count);
         end
      end
   end

endmodule

// File: tb/tb_l1_trace_sequencer.sv
// Scoreboarded bench: stand-in LRU processor, recency-list reference model, directed plus random traces.
module tb_l1_trace_sequencer;
   import my_struct_package::*;

   typedef cache_line_t [7:0] lines8_t;

   typedef struct {
      int          low;
      logic [31:0] rd, wr, ht, ms, wb;
      cache_line_t blk;
      command_t    ins;
      logic [15:0] mask;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              cmd_valid = 1'b0;
   command_t          cmd = '0;
   logic              cmd_ready, busy, dump_valid;
   command_t          proc_instruction;
   cache_line_t [3:0] proc_line_i, ret_i;
   cache_line_t [7:0] proc_line_d, ret_d;
   cache_line_t       proc_block_in, blk_out;
   logic [3:0]        dump_set;
   logic [31:0]       read_count, write_count, hit_count, miss_count, writeback_count;

   int vectors = 0;
   int errors  = 0;
   exp_t sb[$];

   // Reference model: per set, lines kept in recency order (index 0 = most recent). a=0 data, a=1 instr.
   logic [11:0] m_tag [2][16][8];
   logic [1:0]  m_st  [2][16][8];
   logic [31:0] m_rd, m_wr, m_ht, m_ms, m_wb;
   cache_line_t last_blk;
   command_t    last_ins;

   always #5 clk = ~clk;

   l1_trace_sequencer #(.SET_BITS(4)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready), .busy(busy),
      .proc_instruction(proc_instruction), .proc_line_i(proc_line_i), .proc_line_d(proc_line_d),
      .proc_block_in(proc_block_in), .proc_return_i(ret_i), .proc_return_d(ret_d),
      .proc_block_out(blk_out), .dump_valid(dump_valid), .dump_set(dump_set),
      .read_count(read_count), .write_count(write_count), .hit_count(hit_count),
      .miss_count(miss_count), .writeback_count(writeback_count)
   );

   // Stand-in processor: LRU-counter replacement, hit updates in place.
   function automatic lines8_t proc_apply(input lines8_t lines, input int ways, input command_t c,
                                          input cache_line_t blk, output cache_line_t victim);
      lines8_t    res = lines;
      int         hw = -1;
      int         vw = 0;
      logic [2:0] old;
      victim = '0;
      for (int w = 0; w < ways; w++)
         if (hw < 0 && lines[w].mesi != MESI_I && lines[w].tag == c.address.tag) hw = w;
      if (hw >= 0) begin
         victim = lines[hw];
         res[hw].mesi = blk.mesi;
         if (c.n <= 4'd2) begin
            old = lines[hw].lru;
            for (int w = 0; w < ways; w++)
               if (lines[w].lru < old) res[w].lru = lines[w].lru + 3'd1;
            res[hw].lru = 3'd0;
         end
      end else if (c.n <= 4'd2) begin
         for (int w = 0; w < ways; w++)
            if (lines[w].lru == 3'(ways - 1)) vw = w;
         victim = lines[vw];
         for (int w = 0; w < ways; w++) res[w].lru = lines[w].lru + 3'd1;
         res[vw] = blk;
      end
      return res;
   endfunction

   lines8_t     p_in, p_out;
   cache_line_t p_vic;
   always_comb begin
      p_in  = '0;
      p_out = '0;
      p_vic = '0;
      ret_i = proc_line_i;
      ret_d = proc_line_d;
      if (proc_instruction.n == 4'd2) begin
         p_in[3:0] = proc_line_i;
         p_out     = proc_apply(p_in, 4, proc_instruction, proc_block_in, p_vic);
         ret_i     = p_out[3:0];
      end else begin
         p_out = proc_apply(proc_line_d, 8, proc_instruction, proc_block_in, p_vic);
         ret_d = p_out;
      end
      blk_out = p_vic;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear_storage();
      for (int a = 0; a < 2; a++)
         for (int st = 0; st < 16; st++)
            for (int w = 0; w < 8; w++) begin
               m_tag[a][st][w] = '0;
               m_st[a][st][w]  = MESI_I;
            end
   endtask

   task automatic model_reset();
      model_clear_storage();
      {m_rd, m_wr, m_ht, m_ms, m_wb} = '0;
      last_blk = '0;
      last_ins = '0;
   endtask

   function automatic logic [15:0] model_mask();
      logic [15:0] m = '0;
      for (int a = 0; a < 2; a++)
         for (int st = 0; st < 16; st++)
            for (int w = 0; w < 8; w++)
               if (m_st[a][st][w] != MESI_I) m[st] = 1'b1;
      return m;
   endfunction

   task automatic model_access(input command_t c);
      int          a    = (c.n == 4'd2) ? 1 : 0;
      int          ways = (c.n == 4'd2) ? 4 : 8;
      int          st   = int'(c.address.index[3:0]);
      int          pos  = -1;
      logic [1:0]  b;
      for (int p = 0; p < ways; p++)
         if (pos < 0 && m_st[a][st][p] != MESI_I && m_tag[a][st][p] == c.address.tag) pos = p;
      case (c.n)
         4'd0, 4'd2: b = (pos >= 0) ? m_st[a][st][pos] : MESI_E;
         4'd1:       b = MESI_M;
         4'd4:       b = (pos >= 0) ? MESI_S : MESI_I;
         default:    b = MESI_I;
      endcase
      if (c.n <= 4'd2) begin
         if (c.n == 4'd1) m_wr++; else m_rd++;
         if (pos >= 0) m_ht++;
         else begin
            m_ms++;
            if (m_st[a][st][ways-1] == MESI_M) m_wb++;
            pos = ways - 1;
         end
         for (int p = pos; p > 0; p--) begin
            m_tag[a][st][p] = m_tag[a][st][p-1];
            m_st[a][st][p]  = m_st[a][st][p-1];
         end
         m_tag[a][st][0] = c.address.tag;
         m_st[a][st][0]  = b;
      end else if (pos >= 0) begin
         m_st[a][st][pos] = b;
      end
      last_blk = '{mesi: b, tag: c.address.tag, lru: 3'd0};
      last_ins = c;
   endtask

   task automatic push_exp(input int low, input logic [15:0] mask);
      exp_t e;
      e.low = low;
      e.rd = m_rd; e.wr = m_wr; e.ht = m_ht; e.ms = m_ms; e.wb = m_wb;
      e.blk = last_blk;
      e.ins = last_ins;
      e.mask = mask;
      sb.push_back(e);
   endtask

   task automatic send(input logic [3:0] n, input logic [11:0] tag, input int set, input bit abort);
      command_t c;
      int t = 0;
      c = '{n: n, address: '{tag: tag, index: 14'(set)}};
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd = c;
      while (!cmd_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!cmd_ready) begin
         check("ready_timeout", 64'(cmd_ready), 64'd1);
         cmd_valid = 1'b0;
         return;
      end
      if (n <= 4'd4 && !abort) begin
         model_access(c);
         push_exp(2, 16'h0);
      end else if (n == 4'd8) begin
         model_clear_storage();
         {m_rd, m_wr, m_ht, m_ms, m_wb} = '0;
         push_exp(16, 16'h0);
      end else if (n == 4'd9) begin
         push_exp(16, model_mask());
      end
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      if (n > 4'd4 && n != 4'd8 && n != 4'd9) check("ignored_op_ready", 64'(cmd_ready), 64'd1);
      if (abort) begin
         @(posedge clk);
         #1 rst_n = 1'b0;
         model_reset();
         push_exp(16, 16'h0);
         repeat (2) @(posedge clk);
         #1 rst_n = 1'b1;
      end
   endtask

   // Monitor: each rising cmd_ready completes one scoreboard entry.
   initial begin
      logic        prev = 1'b0;
      int          low  = 0;
      logic [15:0] mask = '0;
      exp_t        e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev = 1'b0;
            low  = 0;
            mask = '0;
            check("reset_ready", 64'(cmd_ready), 64'd0);
         end else begin
            if (dump_valid) mask = mask | (16'd1 << dump_set);
            if (cmd_ready && !prev) begin
               if (sb.size() == 0) begin
                  check("unexpected_ready", 64'd1, 64'd0);
               end else begin
                  e = sb.pop_front();
                  check("ready_low_cycles", 64'(low), 64'(e.low));
                  check("read_count", 64'(read_count), 64'(e.rd));
                  check("write_count", 64'(write_count), 64'(e.wr));
                  check("hit_count", 64'(hit_count), 64'(e.ht));
                  check("miss_count", 64'(miss_count), 64'(e.ms));
                  check("writeback_count", 64'(writeback_count), 64'(e.wb));
                  check("proc_block_in", 64'(proc_block_in), 64'(e.blk));
                  check("proc_instruction", 64'(proc_instruction), 64'(e.ins));
                  check("dump_mask", 64'(mask), 64'(e.mask));
               end
               low  = 0;
               mask = '0;
            end else if (!cmd_ready) begin
               low++;
               check("busy_when_not_ready", 64'(busy), 64'd1);
            end
            prev = cmd_ready;
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1);
   end

   initial begin
      int t;
      logic [3:0] op;
      model_reset();
      push_exp(16, 16'h0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      send(4'd0, 12'h012, 3, 0);
      send(4'd0, 12'h012, 3, 0);
      send(4'd1, 12'h012, 3, 0);
      send(4'd4, 12'h012, 3, 0);
      for (int k = 0; k < 9; k++) send(4'd1, 12'h040 + 12'(k), 5, 0);
      send(4'd0, 12'h060, 5, 0);
      send(4'd2, 12'h070, 7, 0);
      send(4'd2, 12'h070, 7, 0);
      send(4'd9, 12'h000, 0, 0);
      send(4'd8, 12'h000, 0, 0);
      send(4'd9, 12'h000, 0, 0);
      send(4'd0, 12'h012, 3, 1);
      send(4'd7, 12'h000, 0, 0);
      send(4'd0, 12'h012, 3, 0);

      for (int i = 0; i < 200; i++) begin
         case ($urandom_range(0, 19))
            0:       op = 4'd9;
            1:       op = 4'd8;
            2:       op = 4'd6;
            3, 4:    op = 4'd3;
            5, 6, 7: op = 4'd4;
            8, 9, 10: op = 4'd2;
            11, 12, 13: op = 4'd1;
            default: op = 4'd0;
         endcase
         send(op, 12'h010 + 12'($urandom_range(0, 9)), ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2), 0);
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end

      t = 0;
      while (sb.size() != 0 && t < 200) begin
         @(posedge clk);
         t++;
      end
      check("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
